// File: rtl/cache_mem_arbiter.sv
// Shares one downstream memory port between I-cache refills and D-cache refills/writebacks.
// One line transaction at a time, round-robin on ties, burst address phase then data beats.
module cache_mem_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned BEATS  = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ic_req,
  input  logic [ADDR_W-1:0]   ic_addr,
  output logic                ic_gnt,
  output logic                ic_rvalid,
  output logic [DATA_W-1:0]   ic_rdata,
  output logic                ic_done,
  input  logic                dc_req,
  input  logic                dc_we,
  input  logic [ADDR_W-1:0]   dc_addr,
  output logic                dc_gnt,
  input  logic [DATA_W-1:0]   dc_wdata,
  input  logic [DATA_W/8-1:0] dc_wstrb,
  output logic                dc_wready,
  output logic                dc_rvalid,
  output logic [DATA_W-1:0]   dc_rdata,
  output logic                dc_done,
  output logic                m_req,
  output logic                m_we,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [3:0]          m_len,
  input  logic                m_ack,
  output logic                m_wvalid,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  output logic                m_wlast,
  input  logic                m_wready,
  input  logic                m_rvalid,
  input  logic [DATA_W-1:0]   m_rdata,
  input  logic                m_bvalid
);

  localparam int unsigned CntW = $clog2(BEATS) + 1;
  localparam logic [CntW-1:0] LastBeat = CntW'(BEATS - 1);

  typedef enum logic [2:0] {StIdle, StAddr, StRData, StWData, StWResp} state_e;

  state_e              state_q, state_d;
  logic                owner_q, owner_d;  // 1 = D-cache owns the transaction
  logic                last_q, last_d;    // previous owner, same encoding
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                gnt_ic, gnt_dc;
  logic                cnt_last;

  assign cnt_last = (cnt_q == LastBeat);

  // On a tie the requester that did not own the previous transaction wins.
  always_comb begin
    gnt_ic = 1'b0;
    gnt_dc = 1'b0;
    if (state_q == StIdle && !rst) begin
      if (ic_req && (!dc_req || last_q)) begin
        gnt_ic = 1'b1;
      end else if (dc_req) begin
        gnt_dc = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    we_d    = we_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        if (gnt_ic) begin
          owner_d = 1'b0;
          last_d  = 1'b0;
          we_d    = 1'b0;
          addr_d  = ic_addr;
          state_d = StAddr;
        end else if (gnt_dc) begin
          owner_d = 1'b1;
          last_d  = 1'b1;
          we_d    = dc_we;
          addr_d  = dc_addr;
          state_d = StAddr;
        end
      end
      StAddr: begin
        if (m_ack) state_d = we_q ? StWData : StRData;
      end
      StRData: begin
        if (m_rvalid) begin
          if (cnt_last) begin
            cnt_d   = '0;
            state_d = StIdle;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StWData: begin
        if (m_wready) begin
          if (cnt_last) begin
            cnt_d   = '0;
            state_d = StWResp;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StWResp: begin
        if (m_bvalid) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Every output is forced low while rst is high, including the combinational paths.
  always_comb begin
    ic_gnt    = 1'b0;
    ic_rvalid = 1'b0;
    ic_rdata  = '0;
    ic_done   = 1'b0;
    dc_gnt    = 1'b0;
    dc_wready = 1'b0;
    dc_rvalid = 1'b0;
    dc_rdata  = '0;
    dc_done   = 1'b0;
    m_req     = 1'b0;
    m_we      = 1'b0;
    m_addr    = '0;
    m_len     = '0;
    m_wvalid  = 1'b0;
    m_wdata   = '0;
    m_wstrb   = '0;
    m_wlast   = 1'b0;
    if (!rst) begin
      ic_gnt = gnt_ic;
      dc_gnt = gnt_dc;
      case (state_q)
        StAddr: begin
          m_req  = 1'b1;
          m_we   = we_q;
          m_addr = addr_q;
          m_len  = 4'(BEATS - 1);
        end
        StRData: begin
          if (owner_q) begin
            dc_rvalid = m_rvalid;
            dc_rdata  = m_rdata;
            dc_done   = m_rvalid && cnt_last;
          end else begin
            ic_rvalid = m_rvalid;
            ic_rdata  = m_rdata;
            ic_done   = m_rvalid && cnt_last;
          end
        end
        StWData: begin
          m_wvalid  = 1'b1;
          m_wdata   = dc_wdata;
          m_wstrb   = dc_wstrb;
          m_wlast   = cnt_last;
          dc_wready = m_wready;
        end
        StWResp: dc_done = m_bvalid;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      we_q    <= 1'b0;
      addr_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Scoreboard bench for cache_mem_arbiter: requester/memory models push expectations,
// a bus monitor pops and compares them as the arbiter produces output.
module tb_cache_mem_arbiter;

  localparam int AW    = 32;
  localparam int DW    = 64;
  localparam int BEATS = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ic_req, ic_gnt, ic_rvalid, ic_done;
  logic [AW-1:0] ic_addr;
  logic [DW-1:0] ic_rdata;
  logic dc_req, dc_we, dc_gnt, dc_wready, dc_rvalid, dc_done;
  logic [AW-1:0] dc_addr;
  logic [DW-1:0] dc_wdata, dc_rdata;
  logic [DW/8-1:0] dc_wstrb;
  logic m_req, m_we, m_ack, m_wvalid, m_wlast, m_wready, m_rvalid, m_bvalid;
  logic [AW-1:0] m_addr;
  logic [3:0] m_len;
  logic [DW-1:0] m_wdata, m_rdata;
  logic [DW/8-1:0] m_wstrb;

  always #5 clk = ~clk;

  cache_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .BEATS(BEATS)) dut (
    .clk(clk), .rst(rst),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_gnt(ic_gnt), .ic_rvalid(ic_rvalid),
    .ic_rdata(ic_rdata), .ic_done(ic_done),
    .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_gnt(dc_gnt),
    .dc_wdata(dc_wdata), .dc_wstrb(dc_wstrb), .dc_wready(dc_wready),
    .dc_rvalid(dc_rvalid), .dc_rdata(dc_rdata), .dc_done(dc_done),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_len(m_len), .m_ack(m_ack),
    .m_wvalid(m_wvalid), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast),
    .m_wready(m_wready), .m_rvalid(m_rvalid), .m_rdata(m_rdata), .m_bvalid(m_bvalid)
  );

  typedef struct {bit dc; bit we; logic [AW-1:0] addr;} txn_t;
  typedef struct {bit we; logic [AW-1:0] addr; logic [BEATS-1:0][DW-1:0] w; logic [DW/8-1:0] strb;} dreq_t;
  typedef struct {logic [DW-1:0] d; logic [DW/8-1:0] s;} wbeat_t;
  typedef enum int {PhIdle, PhAddr, PhRead, PhWrite, PhResp} ph_e;

  txn_t          txn_q[$];
  logic [DW-1:0] rd_q[$];
  logic [DW-1:0] exp_rd_q[$];
  wbeat_t        exp_wr_q[$];
  logic [AW-1:0] ic_pend[$];
  dreq_t         dc_pend[$];
  int            gnt_log[$];
  int            done_log[$];

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int ack_dly = 0, wstall = 0, bdly = 0;

  logic all_out;
  assign all_out = |{ic_gnt, ic_rvalid, ic_rdata, ic_done, dc_gnt, dc_wready, dc_rvalid,
                     dc_rdata, dc_done, m_req, m_we, m_addr, m_len, m_wvalid, m_wdata,
                     m_wstrb, m_wlast};

  task automatic check_eq(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Memory/bus model: acks after ack_dly, stalls writes wstall cycles, responds after bdly.
  int ms = 0, mc = 0, md = 0;
  bit mwe = 1'b0;
  initial begin
    m_ack = 0; m_rvalid = 0; m_rdata = '0; m_wready = 0; m_bvalid = 0;
    forever begin
      @(posedge clk); #1;
      m_ack = 0; m_rvalid = 0; m_wready = 0; m_bvalid = 0; m_rdata = '0;
      if (rst) begin
        ms = 0;
      end else begin
        if (ms == 0 && m_req) begin mwe = m_we; md = ack_dly; mc = 0; ms = 1; end
        if (ms == 1) begin
          if (md == 0) begin m_ack = 1; ms = mwe ? 3 : 2; md = mwe ? wstall : 0; end
          else md--;
        end else if (ms == 2) begin
          if (rd_q.size() > 0) m_rdata = rd_q.pop_front();
          else m_rdata = 64'hBAD0_0000_0000_0000 | 64'(mc);
          m_rvalid = 1;
          exp_rd_q.push_back(m_rdata);
          mc++;
          if (mc == BEATS) ms = 0;
        end else if (ms == 3) begin
          if (md > 0) md--;
          else begin
            m_wready = 1; mc++;
            if (mc == BEATS) begin ms = 4; md = bdly; end
          end
        end else if (ms == 4) begin
          if (md > 0) md--;
          else begin m_bvalid = 1; ms = 0; end
        end
      end
    end
  end

  // I-cache requester: holds req until granted, then moves to the next queued address.
  initial begin
    bit g;
    ic_req = 0; ic_addr = '0;
    forever begin
      @(negedge clk); g = ic_req && ic_gnt;
      @(posedge clk); #1;
      if (g && ic_pend.size() > 0) void'(ic_pend.pop_front());
      if (ic_pend.size() > 0) begin ic_req = 1; ic_addr = ic_pend[0]; end
      else begin ic_req = 0; ic_addr = '0; end
    end
  end

  // D-cache requester plus write-beat source advancing on dc_wready.
  initial begin
    bit g, adv;
    int widx;
    dreq_t cur;
    cur.we = 0; cur.addr = '0; cur.w = '0; cur.strb = '0; widx = 0;
    dc_req = 0; dc_we = 0; dc_addr = '0; dc_wdata = '0; dc_wstrb = '0;
    forever begin
      @(negedge clk); g = dc_req && dc_gnt; adv = dc_wready;
      @(posedge clk); #1;
      if (adv) widx++;
      if (g && dc_pend.size() > 0) begin cur = dc_pend.pop_front(); widx = 0; end
      if (dc_pend.size() > 0) begin
        dc_req = 1; dc_we = dc_pend[0].we; dc_addr = dc_pend[0].addr;
      end else begin
        dc_req = 0; dc_we = 0; dc_addr = '0;
      end
      dc_wdata = (widx < BEATS) ? cur.w[widx] : '0;
      dc_wstrb = cur.strb;
    end
  end

  // Bus monitor: pops the expected transaction at grant and checks each phase.
  ph_e ph = PhIdle;
  txn_t cur_t;
  int beat = 0;
  logic [DW-1:0] exp_d;
  wbeat_t exp_w;
  bit lastb;
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      ph = PhIdle; beat = 0;
    end else begin
      if (ph != PhIdle) check_eq("gnt_busy", {ic_gnt, dc_gnt}, 0);
      case (ph)
        PhIdle: begin
          check_eq("idle_out", {m_req, m_wvalid, ic_rvalid, dc_rvalid, ic_done, dc_done}, 0);
          if (ic_gnt || dc_gnt) begin
            check_eq("gnt_onehot", ic_gnt && dc_gnt, 0);
            gnt_log.push_back(cyc);
            if (txn_q.size() == 0) check_eq("gnt_unexpected", 1, 0);
            else begin
              cur_t = txn_q.pop_front();
              check_eq("gnt_owner", dc_gnt, cur_t.dc);
            end
            ph = PhAddr; beat = 0;
          end
        end
        PhAddr: begin
          check_eq("m_req", m_req, 1);
          check_eq("m_addr", m_addr, cur_t.addr);
          check_eq("m_we", m_we, cur_t.we);
          check_eq("m_len", m_len, BEATS - 1);
          check_eq("addr_quiet", {ic_rvalid, dc_rvalid, ic_done, dc_done, m_wvalid}, 0);
          if (m_ack) ph = cur_t.we ? PhWrite : PhRead;
        end
        PhRead: begin
          if (m_rvalid) begin
            if (exp_rd_q.size() == 0) begin check_eq("rd_unexpected", 1, 0); exp_d = '0; end
            else exp_d = exp_rd_q.pop_front();
            lastb = (beat == BEATS - 1);
            check_eq("ic_rvalid", ic_rvalid, !cur_t.dc);
            check_eq("dc_rvalid", dc_rvalid, cur_t.dc);
            check_eq("ic_rdata", ic_rdata, cur_t.dc ? '0 : exp_d);
            check_eq("dc_rdata", dc_rdata, cur_t.dc ? exp_d : '0);
            check_eq("ic_done", ic_done, !cur_t.dc && lastb);
            check_eq("dc_done", dc_done, cur_t.dc && lastb);
            beat++;
            if (lastb) begin ph = PhIdle; done_log.push_back(cyc); end
          end else begin
            check_eq("rd_wait", {ic_rvalid, dc_rvalid, ic_done, dc_done}, 0);
          end
        end
        PhWrite: begin
          check_eq("m_wvalid", m_wvalid, 1);
          check_eq("m_wlast", m_wlast, beat == BEATS - 1);
          check_eq("dc_wready", dc_wready, m_wready);
          check_eq("wr_done", dc_done, 0);
          if (m_wready) begin
            if (exp_wr_q.size() == 0) begin check_eq("wr_unexpected", 1, 0); end
            else begin
              exp_w = exp_wr_q.pop_front();
              check_eq("m_wdata", m_wdata, exp_w.d);
              check_eq("m_wstrb", m_wstrb, exp_w.s);
            end
            beat++;
            if (beat == BEATS) ph = PhResp;
          end
        end
        PhResp: begin
          check_eq("resp_done", dc_done, m_bvalid);
          check_eq("resp_wvalid", m_wvalid, 0);
          if (m_bvalid) begin ph = PhIdle; done_log.push_back(cyc); end
        end
        default: ;
      endcase
    end
  end

  task automatic add_txn(input bit dc, input bit we, input logic [AW-1:0] a);
    txn_t t;
    t.dc = dc; t.we = we; t.addr = a;
    txn_q.push_back(t);
  endtask

  task automatic push_dc(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] w0,
                         input logic [DW-1:0] w1, input logic [DW/8-1:0] s);
    dreq_t r;
    wbeat_t b;
    r.we = we; r.addr = a; r.w[0] = w0; r.w[1] = w1; r.strb = s;
    dc_pend.push_back(r);
    if (we) begin
      b.d = w0; b.s = s; exp_wr_q.push_back(b);
      b.d = w1; exp_wr_q.push_back(b);
    end
  endtask

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic wait_quiet(input string tag);
    int n = 0;
    while (!(ph == PhIdle && txn_q.size() == 0 && ic_pend.size() == 0 && dc_pend.size() == 0)
           && n < 300) begin
      @(negedge clk); #1; n++;
    end
    check_eq({tag, "_complete"}, n < 300, 1);
    tick();
  endtask

  initial begin
    int n;
    // Reset with an I-cache request already pending: nothing may leak out.
    ack_dly = 2; wstall = 0; bdly = 1;
    ic_pend.push_back(32'h8000_0010);
    add_txn(0, 0, 32'h8000_0010);
    rd_q.push_back(64'h11); rd_q.push_back(64'h22);
    repeat (3) begin @(negedge clk); #1; check_eq("rst_outs", all_out, 0); end
    tick(); rst = 0;
    wait_quiet("ic_read");
    check_eq("ic_read_gnts", gnt_log.size(), 1);

    // Writeback with three stall cycles before the first beat is taken.
    wstall = 3; bdly = 2;
    push_dc(1, 32'h4000_0040, 64'hA, 64'hB, 8'hFF);
    add_txn(1, 1, 32'h4000_0040);
    wait_quiet("dc_wb");

    // Tie after reset, then a second tie while the I-cache has another line pending.
    tick(); rst = 1; tick(); rst = 0;
    gnt_log.delete(); done_log.delete();
    ack_dly = 1; wstall = 0; bdly = 0;
    ic_pend.push_back(32'h0000_0100); ic_pend.push_back(32'h0000_0200);
    push_dc(0, 32'h0000_0300, '0, '0, '0);
    add_txn(0, 0, 32'h0000_0100); add_txn(1, 0, 32'h0000_0300); add_txn(0, 0, 32'h0000_0200);
    for (int i = 1; i <= 6; i++) rd_q.push_back(64'(i) * 64'h0101_0101);
    wait_quiet("ties");
    check_eq("tie_gnts", gnt_log.size(), 3);
    if (gnt_log.size() == 3 && done_log.size() >= 2) begin
      check_eq("tie_gap1", gnt_log[1] - done_log[0], 1);
      check_eq("tie_gap2", gnt_log[2] - done_log[1], 1);
    end

    // Back-to-back D-cache refill then writeback with no memory latency.
    gnt_log.delete(); done_log.delete();
    ack_dly = 0;
    push_dc(0, 32'h0000_0500, '0, '0, '0);
    push_dc(1, 32'h0000_0540, 64'hC0DE_0001, 64'hC0DE_0002, 8'h3C);
    add_txn(1, 0, 32'h0000_0500); add_txn(1, 1, 32'h0000_0540);
    rd_q.push_back(64'hFEED_0001); rd_q.push_back(64'hFEED_0002);
    wait_quiet("b2b");
    check_eq("b2b_dones", done_log.size(), 2);
    if (gnt_log.size() == 2 && done_log.size() == 2) begin
      check_eq("rd_latency", done_log[0] - gnt_log[0], 1 + BEATS);
      check_eq("b2b_gap", gnt_log[1] - done_log[0], 1);
      check_eq("wr_latency", done_log[1] - gnt_log[1], 2 + BEATS);
    end

    // Reset after the first write beat abandons the writeback silently.
    done_log.delete();
    push_dc(1, 32'h0000_0600, 64'h600D_0001, 64'h600D_0002, 8'h0F);
    add_txn(1, 1, 32'h0000_0600);
    n = 0;
    while (!(ph == PhWrite && beat == 1) && n < 50) begin @(negedge clk); #1; n++; end
    check_eq("wr_first_beat", n < 50, 1);
    tick(); rst = 1;
    @(negedge clk); #1; check_eq("midrst_outs", all_out, 0);
    tick(); rst = 0;
    exp_wr_q.delete();
    @(negedge clk); #1; check_eq("postrst_outs", all_out, 0);
    check_eq("midrst_no_done", done_log.size(), 0);
    tick();
    ic_pend.push_back(32'h0000_0700);
    add_txn(0, 0, 32'h0000_0700);
    rd_q.push_back(64'h77); rd_q.push_back(64'h78);
    wait_quiet("postrst_read");
    check_eq("postrst_done", done_log.size(), 1);

    check_eq("rd_left", exp_rd_q.size(), 0);
    check_eq("wr_left", exp_wr_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: run did not complete, got timeout, expected finish");
    $fatal(1);
  end

endmodule
